// File: rtl/score_frame_controller_if.sv
// Purpose : bundles the game-control, pixel-side and scorer-side signals of score_frame_controller.
// Latency : none (wiring only).
// Backpressure: none; pixel and scorer strobes are single-cycle valids with no ready.
//
// Port summary (controller view = slave modport):
//   game control : start_in, abort_in -> round_out, score_valid_out, score_out,
//                  total_out, busy_out, done_out, timeout_out
//   pixel side   : pixel_valid_in, hcount_in, vcount_in
//   scorer side  : scorer_valid_in, scorer_score_in -> scorer_rst_out,
//                  scorer_valid_out, scorer_last_out
// The master modport is the environment's view (pipeline, scorer and game logic).
// HRES/VRES/ROUNDS must match the controller instance they connect to.
interface score_frame_controller_if #(
    parameter int HRES   = 320,
    parameter int VRES   = 180,
    parameter int ROUNDS = 4
);
    localparam int HW = $clog2(HRES);
    localparam int VW = $clog2(VRES);
    localparam int RW = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;
    localparam int TW = $clog2(7 * ROUNDS + 1);

    // game control
    logic          start_in;
    logic          abort_in;
    logic [RW-1:0] round_out;
    logic          score_valid_out;
    logic [2:0]    score_out;
    logic [TW-1:0] total_out;
    logic          busy_out;
    logic          done_out;
    logic          timeout_out;

    // pixel pipeline
    logic          pixel_valid_in;
    logic [HW-1:0] hcount_in;
    logic [VW-1:0] vcount_in;

    // scorer
    logic          scorer_rst_out;
    logic          scorer_valid_out;
    logic          scorer_last_out;
    logic          scorer_valid_in;
    logic [2:0]    scorer_score_in;

    modport slave (
        input  start_in, abort_in,
        input  pixel_valid_in, hcount_in, vcount_in,
        input  scorer_valid_in, scorer_score_in,
        output scorer_rst_out, scorer_valid_out, scorer_last_out,
        output round_out, score_valid_out, score_out, total_out,
        output busy_out, done_out, timeout_out
    );

    modport master (
        output start_in, abort_in,
        output pixel_valid_in, hcount_in, vcount_in,
        output scorer_valid_in, scorer_score_in,
        input  scorer_rst_out, scorer_valid_out, scorer_last_out,
        input  round_out, score_valid_out, score_out, total_out,
        input  busy_out, done_out, timeout_out
    );
endinterface

// File: rtl/score_frame_controller.sv
// Purpose : sequences the pose scorer over a multi-round game: clear, align to frame origin,
//           forward one frame, collect the 3-bit result, accumulate the game total.
// Latency : pixel strobe to scorer_valid_out/scorer_last_out 1 cycle; scorer result to score_valid_out 1 cycle.
// Backpressure: none; pixels arriving outside the scoring window are dropped, and the
//           controller waits in WAIT for the scorer (bounded only when SCORE_TIMEOUT_EN is defined).
//
// Ports: clk_in, rst_in (asynchronous, active-high) plus bus (score_frame_controller_if.slave),
//        see the interface file for the signal list.
// Optional feature: define SCORE_TIMEOUT_EN to bound the result wait to TIMEOUT cycles; on expiry
//        the round scores 7 and timeout_out is set. Undefined: WAIT never times out and
//        timeout_out stays 0.
module score_frame_controller #(
    parameter int HRES    = 320,
    parameter int VRES    = 180,
    parameter int ROUNDS  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    score_frame_controller_if.slave   bus
);
    localparam int HW = $clog2(HRES);
    localparam int VW = $clog2(VRES);
    localparam int RW = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;
    localparam int TW = $clog2(7 * ROUNDS + 1);

    // One extra bit on the limits so HRES/VRES themselves are representable.
    localparam logic [HW:0]   H_LIM  = (HW + 1)'(HRES);
    localparam logic [VW:0]   V_LIM  = (VW + 1)'(VRES);
    localparam logic [HW-1:0] H_LAST = HW'(HRES - 1);
    localparam logic [VW-1:0] V_LAST = VW'(VRES - 1);
    localparam logic [RW-1:0] R_LAST = RW'(ROUNDS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_SYNC  = 3'd2;
    localparam logic [2:0] S_SCORE = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_NEXT  = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    logic [2:0] state;
    logic [2:0] state_nxt;

    logic       pix_in_frame;
    logic       pix_origin;
    logic       pix_last;
    logic       abort_hit;
    logic       game_start;
    logic       fwd;
    logic       fwd_last;
    logic       take_result;
    logic       timeout_hit;
    logic       round_adv;
    logic [2:0] result;

    // ------------------------------------------------------------------
    // Pixel qualification
    // ------------------------------------------------------------------
    assign pix_in_frame = bus.pixel_valid_in
                       && ({1'b0, bus.hcount_in} < H_LIM)
                       && ({1'b0, bus.vcount_in} < V_LIM);
    assign pix_origin   = pix_in_frame && (bus.hcount_in == '0) && (bus.vcount_in == '0);
    assign pix_last     = pix_in_frame && (bus.hcount_in == H_LAST) && (bus.vcount_in == V_LAST);

    // Abort only means something once a game is running; in IDLE a start wins.
    assign abort_hit  = bus.abort_in && (state != S_IDLE);
    assign game_start = (state == S_IDLE) && bus.start_in;

    // ------------------------------------------------------------------
    // Result wait bound
    // ------------------------------------------------------------------
`ifdef SCORE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt;

    // wait_cnt holds the number of WAIT cycles already completed, so the
    // TIMEOUT-th WAIT cycle is the one where it reads TIMEOUT-1.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + CW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    // A real result on the expiry cycle takes precedence.
    assign timeout_hit = (state == S_WAIT) && !bus.scorer_valid_in
                      && (wait_cnt == CW'(TIMEOUT - 1));
`else
    // TIMEOUT only matters when the timeout is built in.
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT > 0);
    assign timeout_hit    = 1'b0;
`endif

    assign take_result = (state == S_WAIT) && !bus.abort_in
                      && (bus.scorer_valid_in || timeout_hit);
    assign result      = bus.scorer_valid_in ? bus.scorer_score_in : 3'd7;

    // ------------------------------------------------------------------
    // Next state and pixel forwarding decision
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        fwd       = 1'b0;
        fwd_last  = 1'b0;

        if (state == S_IDLE) begin
            if (bus.start_in) begin
                state_nxt = S_CLEAR;
            end
        end else if (bus.abort_in) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_CLEAR: begin
                    state_nxt = S_SYNC;
                end
                S_SYNC: begin
                    // Only the frame origin starts a round; a 1x1 frame is also its own last pixel.
                    if (pix_origin) begin
                        fwd = 1'b1;
                        if (pix_last) begin
                            fwd_last  = 1'b1;
                            state_nxt = S_WAIT;
                        end else begin
                            state_nxt = S_SCORE;
                        end
                    end
                end
                S_SCORE: begin
                    if (pix_in_frame) begin
                        fwd = 1'b1;
                        if (pix_last) begin
                            fwd_last  = 1'b1;
                            state_nxt = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.scorer_valid_in || timeout_hit) begin
                        state_nxt = S_NEXT;
                    end
                end
                S_NEXT: begin
                    state_nxt = (bus.round_out == R_LAST) ? S_DONE : S_CLEAR;
                end
                S_DONE: begin
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign round_adv = (state == S_NEXT) && (state_nxt == S_CLEAR);

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state                <= S_IDLE;
            bus.scorer_rst_out   <= 1'b0;
            bus.scorer_valid_out <= 1'b0;
            bus.scorer_last_out  <= 1'b0;
            bus.round_out        <= '0;
            bus.score_valid_out  <= 1'b0;
            bus.score_out        <= '0;
            bus.total_out        <= '0;
            bus.busy_out         <= 1'b0;
            bus.done_out         <= 1'b0;
            bus.timeout_out      <= 1'b0;
        end else begin
            state                <= state_nxt;
            // CLEAR lasts exactly one cycle, so entering it yields a one-cycle clear;
            // an abort also clears the scorer so a half-scored frame cannot leak.
            bus.scorer_rst_out   <= (state_nxt == S_CLEAR) || abort_hit;
            bus.scorer_valid_out <= fwd;
            bus.scorer_last_out  <= fwd_last;
            bus.busy_out         <= (state_nxt != S_IDLE);
            bus.done_out         <= (state_nxt == S_DONE);
            bus.score_valid_out  <= take_result;

            if (game_start) begin
                bus.round_out   <= '0;
                bus.score_out   <= '0;
                bus.total_out   <= '0;
                bus.timeout_out <= 1'b0;
            end

            if (take_result) begin
                bus.score_out <= result;
                // TW is sized for 7*ROUNDS, so the sum cannot wrap.
                bus.total_out <= bus.total_out + TW'(result);
                if (!bus.scorer_valid_in) begin
                    bus.timeout_out <= 1'b1;
                end
            end

            if (round_adv) begin
                bus.round_out <= bus.round_out + RW'(1);
            end
        end
    end
endmodule
